resamp_gain_path: RTL and testbench

RESAMP_GAIN_PATH -- requirements
Module: resamp_gain_path

---
 rtl/resamp_pkg.sv | 22 ++
 rtl/resamp_fifo.sv | 79 +++++++
 rtl/resamp_gain_path.sv | 136 +++++++++++++
 tb/tb_resamp_gain_path.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resamp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : resamp_pkg
// Brief    : Mode encodings and width helper shared by the resample/gain path.
// Revision : 1.0 - initial release
// ============================================================================
package resamp_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_RESAMP = 2'b01,
      MODE_MUTE   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   // Occupancy needs one extra bit so that "full" is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/resamp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resamp_fifo
// Brief    : Synchronous FIFO with clear, registered read data and level.
// Revision : 1.0 - initial release
// ============================================================================
module resamp_fifo
   import resamp_pkg::*;
#(
   parameter int WIDTH = 14,
   parameter int DEPTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_clr,
   input  logic                            i_wr_en,
   input  logic [WIDTH-1:0]                i_wr_data,
   input  logic                            i_rd_en,
   output logic [WIDTH-1:0]                o_rd_data,
   output logic                            o_full,
   output logic                            o_empty,
   output logic [level_width(DEPTH)-1:0]   o_level
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_lw = level_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_lw-1:0]  r_level;
   logic [WIDTH-1:0] r_rd_data;
   logic             w_rd_ok;
   logic             w_wr_ok;

   assign o_full    = (r_level == c_lw'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rd_data = r_rd_data;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts
   // a write that coincides with a read.
   assign w_rd_ok = i_rd_en && !o_empty;
   assign w_wr_ok = i_wr_en && (!o_full || w_rd_ok);

   always_ff @(posedge clk) begin
      if (!rst && !i_clr && w_wr_ok) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_rd_data <= '0;
      end else if (i_clr) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_data <= r_mem[r_rd_ptr];
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/resamp_gain_path.sv
`default_nettype none
// ============================================================================
// Module   : resamp_gain_path
// Brief    : ADC->DAC path with block-average decimation, shift gain, FIFO
//            and sample-hold interpolation; bypass and mute modes.
// Revision : 1.0 - initial release
// ============================================================================
module resamp_gain_path
   import resamp_pkg::*;
#(
   parameter int DATA_WIDTH  = 14,
   parameter int SAMPLE_RATE = 2,
   parameter int GAIN_SHIFT  = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_in,
   input  logic                                  in_valid,
   input  logic signed [DATA_WIDTH-1:0]          in_data,
   input  logic [1:0]                            mode,
   input  logic                                  out_en,
   output logic signed [DATA_WIDTH-1:0]          out_data,
   output logic [level_width(FIFO_DEPTH)-1:0]    fifo_level,
   output logic [15:0]                           ovf_cnt,
   output logic                                  udf_flag
);

   localparam int c_acc_w = DATA_WIDTH + SAMPLE_RATE;
   localparam int c_cnt_w = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'((1 << SAMPLE_RATE) - 1);

   logic [1:0]                   r_mode_q;
   logic signed [c_acc_w-1:0]    r_acc;
   logic [c_cnt_w-1:0]           r_phase;
   logic [c_cnt_w-1:0]           r_hold;
   logic                         r_wr_en;
   logic signed [DATA_WIDTH-1:0] r_wr_data;
   logic [15:0]                  r_ovf_cnt;
   logic                         r_udf;

   logic                         w_clr;
   logic                         w_mute;
   logic                         w_bypass;
   logic                         w_resamp;
   logic                         w_take;
   logic                         w_done;
   logic signed [c_acc_w-1:0]    w_sum;
   logic signed [DATA_WIDTH-1:0] w_avg;
   logic signed [DATA_WIDTH-1:0] w_word;
   logic                         w_pop_req;
   logic                         w_hold_adv;
   logic                         w_wr_drop;
   logic                         w_fifo_full;
   logic                         w_fifo_empty;
   logic signed [DATA_WIDTH-1:0] w_fifo_rd_data;

   assign w_clr    = (mode != r_mode_q);
   assign w_mute   = mode[1];
   assign w_bypass = (mode == MODE_BYPASS);
   assign w_resamp = (mode == MODE_RESAMP);

   assign w_take = in_valid && !w_mute;
   assign w_done = w_bypass || (r_phase == c_last);
   assign w_sum  = r_acc + c_acc_w'(in_data);
   assign w_avg  = w_bypass ? in_data : $signed(DATA_WIDTH'(w_sum >>> SAMPLE_RATE));
   assign w_word = w_avg >>> GAIN_SHIFT;

   // Bypass pops on every strobe; resample pops only at the start of a hold.
   assign w_pop_req  = out_en && !w_clr && (w_bypass || (w_resamp && (r_hold == '0)));
   assign w_hold_adv = out_en && w_resamp && ((r_hold != '0) || !w_fifo_empty);
   assign w_wr_drop  = r_wr_en && !w_clr && w_fifo_full && !(w_pop_req && !w_fifo_empty);

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         r_mode_q  <= mode;
         r_acc     <= '0;
         r_phase   <= '0;
         r_hold    <= '0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
         r_ovf_cnt <= '0;
         r_udf     <= 1'b0;
      end else begin
         r_mode_q <= mode;
         r_wr_en  <= 1'b0;
         if (w_clr) begin
            r_acc   <= '0;
            r_phase <= '0;
            r_hold  <= '0;
         end else begin
            if (w_take) begin
               if (w_done) begin
                  r_acc     <= '0;
                  r_phase   <= '0;
                  r_wr_en   <= 1'b1;
                  r_wr_data <= w_word;
               end else begin
                  r_acc   <= w_sum;
                  r_phase <= r_phase + 1'b1;
               end
            end
            if (w_hold_adv) begin
               r_hold <= (r_hold == c_last) ? '0 : r_hold + 1'b1;
            end
            if (w_wr_drop && (r_ovf_cnt != 16'hFFFF)) begin
               r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
            if (w_pop_req && w_fifo_empty) begin
               r_udf <= 1'b1;
            end
         end
      end
   end

   resamp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (!rst_in),
      .i_clr     (w_clr),
      .i_wr_en   (r_wr_en),
      .i_wr_data (r_wr_data),
      .i_rd_en   (w_pop_req),
      .o_rd_data (w_fifo_rd_data),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_level   (fifo_level)
   );

   assign out_data = w_mute ? '0 : w_fifo_rd_data;
   assign ovf_cnt  = r_ovf_cnt;
   assign udf_flag = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_resamp_gain_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_resamp_gain_path
// Brief    : Directed and random checks of resamp_gain_path against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resamp_gain_path;

   localparam int DW    = 14;
   localparam int SR    = 2;
   localparam int GS    = 1;
   localparam int DEPTH = 16;
   localparam int R     = 1 << SR;

   logic                 clk = 1'b0;
   logic                 rst_in;
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic [1:0]           mode;
   logic                 out_en;
   logic signed [DW-1:0] out_data;
   logic [4:0]           fifo_level;
   logic [15:0]          ovf_cnt;
   logic                 udf_flag;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state: a queue stands in for the FIFO.
   bit [1:0] m_mode_q;
   int       m_sum, m_cnt, m_hold;
   bit       m_pend;
   int       m_pend_val;
   int       m_q[$];
   int       m_out;
   int       m_ovf;
   bit       m_udf;

   resamp_gain_path #(
      .DATA_WIDTH  (DW),
      .SAMPLE_RATE (SR),
      .GAIN_SHIFT  (GS),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .mode       (mode),
      .out_en     (out_en),
      .out_data   (out_data),
      .fifo_level (fifo_level),
      .ovf_cnt    (ovf_cnt),
      .udf_flag   (udf_flag)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic signed [31:0] obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit mute, pop_req, pop_ok;
      int x;
      if (!rst_in) begin
         m_mode_q = mode;
         m_sum = 0; m_cnt = 0; m_hold = 0;
         m_pend = 0; m_q.delete();
         m_out = 0; m_ovf = 0; m_udf = 0;
         return;
      end
      mute = mode[1];
      if (mode != m_mode_q) begin
         m_q.delete();
         m_sum = 0; m_cnt = 0; m_hold = 0; m_pend = 0;
         m_mode_q = mode;
         return;
      end
      pop_req = out_en && !mute && (mode == 2'b00 || m_hold == 0);
      pop_ok  = pop_req && (m_q.size() > 0);
      if (pop_ok) m_out = m_q.pop_front();
      if (pop_req && !pop_ok) m_udf = 1;
      if (m_pend) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_pend_val);
         else if (m_ovf < 65535) m_ovf++;
      end
      if (mode == 2'b01 && out_en) begin
         if (m_hold != 0) m_hold = (m_hold + 1) % R;
         else if (pop_ok) m_hold = 1 % R;
      end
      m_pend = 0;
      if (in_valid && !mute) begin
         x = in_data;
         if (mode == 2'b00) begin
            m_pend = 1;
            m_pend_val = x >>> GS;
         end else begin
            m_sum += x;
            m_cnt++;
            if (m_cnt == R) begin
               m_pend = 1;
               m_pend_val = (m_sum >>> SR) >>> GS;
               m_sum = 0;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      chk_val("out_data", out_data, mode[1] ? 0 : m_out);
      chk_val("fifo_level", fifo_level, m_q.size());
      chk_val("ovf_cnt", ovf_cnt, m_ovf);
      chk_val("udf_flag", udf_flag, int'(m_udf));
   endtask

   task automatic cyc(input bit rst_n, input bit vld, input int data,
                      input bit [1:0] md, input bit oe);
      rst_in   = rst_n;
      in_valid = vld;
      in_data  = DW'(data);
      mode     = md;
      out_en   = oe;
      @(posedge clk);
      #1;
      model_step();
      check_all();
   endtask

   task automatic idle(input bit [1:0] md, input int n);
      for (int k = 0; k < n; k++) cyc(1, 0, 0, md, 0);
   endtask

   initial begin
      bit [1:0] md;
      bit       rst_n, vld, oe;
      int       v;
      int       a[3];

      rst_in = 0; in_valid = 0; in_data = '0; mode = 2'b01; out_en = 0;

      // Reset state
      cyc(0, 0, 0, 2'b01, 0);
      cyc(0, 0, 0, 2'b01, 0);
      chk_val("rst_out", out_data, 0);
      chk_val("rst_level", fifo_level, 0);

      // Block average 100..400 -> 250 >>> 1 = 125, held for R strobes
      cyc(1, 1, 100, 2'b01, 0);
      cyc(1, 1, 200, 2'b01, 0);
      cyc(1, 1, 300, 2'b01, 0);
      cyc(1, 1, 400, 2'b01, 0);
      idle(2'b01, 2);
      chk_val("avg_level", fifo_level, 1);
      for (int k = 0; k < R; k++) begin
         cyc(1, 0, 0, 2'b01, 1);
         chk_val("avg_hold", out_data, 125);
      end
      chk_val("avg_popped_once", fifo_level, 0);

      // Floor on negatives: -5/4 -> -2, then >>> 1 -> -1
      cyc(1, 1, -1, 2'b01, 0);
      cyc(1, 1, -1, 2'b01, 0);
      cyc(1, 1, -1, 2'b01, 0);
      cyc(1, 1, -2, 2'b01, 0);
      idle(2'b01, 2);
      cyc(1, 0, 0, 2'b01, 1);
      chk_val("neg_floor", out_data, -1);
      for (int k = 1; k < R; k++) cyc(1, 0, 0, 2'b01, 1);

      // Bypass overflow: 18 writes into 16 slots
      idle(2'b00, 1);
      for (int k = 0; k < 18; k++) cyc(1, 1, 1001 + 10 * k, 2'b00, 0);
      idle(2'b00, 2);
      chk_val("ovf_level", fifo_level, 16);
      chk_val("ovf_count", ovf_cnt, 2);
      cyc(1, 0, 0, 2'b00, 1);
      chk_val("ovf_first_pop", out_data, 500);

      // Underflow on empty FIFO, then retry succeeds
      idle(2'b01, 1);
      cyc(1, 0, 0, 2'b01, 1);
      chk_val("udf_hold_out", out_data, 500);
      chk_val("udf_set", udf_flag, 1);
      for (int k = 0; k < R; k++) cyc(1, 1, 8, 2'b01, 0);
      idle(2'b01, 2);
      cyc(1, 0, 0, 2'b01, 1);
      chk_val("udf_retry_pop", out_data, 4);
      for (int k = 1; k < R; k++) cyc(1, 0, 0, 2'b01, 1);

      // Mode change flushes queued words and partial accumulation
      for (int k = 0; k < 3 * R; k++) cyc(1, 1, 40 * k, 2'b01, 0);
      idle(2'b01, 2);
      chk_val("flush_pre_level", fifo_level, 3);
      cyc(1, 1, 7, 2'b01, 0);
      cyc(1, 1, 9, 2'b01, 0);
      cyc(1, 0, 0, 2'b00, 0);
      chk_val("flush_level", fifo_level, 0);
      a[0] = 40; a[1] = 60; a[2] = -80;
      for (int k = 0; k < 3; k++) cyc(1, 1, a[k], 2'b00, 0);
      idle(2'b00, 2);
      chk_val("bypass_level", fifo_level, 3);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0, 2'b00, 1);
         chk_val("bypass_out", out_data, a[k] >>> GS);
      end

      // Reset mid-hold
      idle(2'b01, 1);
      for (int k = 0; k < 2 * R; k++) cyc(1, 1, 16, 2'b01, 0);
      idle(2'b01, 2);
      cyc(1, 0, 0, 2'b01, 1);
      cyc(1, 0, 0, 2'b01, 1);
      cyc(0, 0, 0, 2'b01, 0);
      chk_val("midrst_out", out_data, 0);
      chk_val("midrst_level", fifo_level, 0);
      chk_val("midrst_ovf", ovf_cnt, 0);
      chk_val("midrst_udf", udf_flag, 0);
      cyc(1, 0, 0, 2'b01, 1);
      chk_val("midrst_retry_udf", udf_flag, 1);

      // Random traffic with occasional mode changes and resets
      md = 2'b01;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(63) == 0) md = 2'($urandom_range(3));
         rst_n = ($urandom_range(499) != 0);
         vld   = 1'($urandom_range(1));
         oe    = ((i / 400) % 2 == 1) ? ($urandom_range(9) < 8) : ($urandom_range(9) < 2);
         v     = int'($urandom);
         cyc(rst_n, vld, v, md, oe);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
